mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the memory port.
// The arbiter takes the slave view; the environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ireq_valid;
  logic [AW-1:0] ireq_addr;
  logic          iresp_addr_ok;
  logic          iresp_data_ok;
  logic [DW-1:0] iresp_data;

  logic            dreq_valid;
  logic [AW-1:0]   dreq_addr;
  logic [DW/8-1:0] dreq_strobe;
  logic [DW-1:0]   dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [DW-1:0]   dresp_data;

  logic            mreq_valid;
  logic            mreq_write;
  logic [AW-1:0]   mreq_addr;
  logic [DW/8-1:0] mreq_strobe;
  logic [DW-1:0]   mreq_data;
  logic            mresp_addr_ok;
  logic            mresp_data_ok;
  logic [DW-1:0]   mresp_data;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok,
    output iresp_data,
    input  dreq_valid, dreq_addr,
    input  dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok,
    output dresp_data,
    output mreq_valid, mreq_write,
    output mreq_addr, mreq_strobe,
    output mreq_data,
    input  mresp_addr_ok, mresp_data_ok,
    input  mresp_data
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok,
    input  iresp_data,
    output dreq_valid, dreq_addr,
    output dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok,
    input  dresp_data,
    input  mreq_valid, mreq_write,
    input  mreq_addr, mreq_strobe,
    input  mreq_data,
    output mresp_addr_ok, mresp_data_ok,
    output mresp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) to single memory port arbiter, one access in
// flight, data priority with a bounded fetch starvation window.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = DW / 8;
  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_e;

  state_e        state_q, state_d;
  logic          own_d_q, own_d_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] strb_q, strb_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic any_req;
  logic gnt_d;
  logic in_addr;
  logic in_busy;

  assign any_req = bus.ireq_valid | bus.dreq_valid;

  // Fetch wins only once the data port has used up its window.
  assign gnt_d = bus.dreq_valid &
    ~(bus.ireq_valid & (cnt_q == CMAX));

  always_comb begin
    state_d = state_q;
    own_d_d = own_d_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ADDR;
          own_d_d = gnt_d;
          if (gnt_d) begin
            addr_d = bus.dreq_addr;
            strb_d = bus.dreq_strobe;
            data_d = bus.dreq_data;
          end else begin
            addr_d = bus.ireq_addr;
            strb_d = '0;
            data_d = '0;
          end
          if (gnt_d && bus.ireq_valid) begin
            if (cnt_q != CMAX) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      ADDR: begin
        if (bus.mresp_addr_ok) begin
          state_d = bus.mresp_data_ok ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bus.mresp_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_addr = (state_q == ADDR);
  assign in_busy = (state_q == ADDR) | (state_q == DATA);

  assign bus.mreq_valid  = in_addr;
  assign bus.mreq_write  = |strb_q;
  assign bus.mreq_addr   = addr_q;
  assign bus.mreq_strobe = strb_q;
  assign bus.mreq_data   = data_q;

  assign bus.iresp_addr_ok =
    in_addr & ~own_d_q & bus.mresp_addr_ok;
  assign bus.iresp_data_ok =
    in_busy & ~own_d_q & bus.mresp_data_ok;
  assign bus.dresp_addr_ok =
    in_addr & own_d_q & bus.mresp_addr_ok;
  assign bus.dresp_data_ok =
    in_busy & own_d_q & bus.mresp_data_ok;

  assign bus.iresp_data = bus.mresp_data;
  assign bus.dresp_data = bus.mresp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// reference of the arbiter.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic clk;
  logic resetn;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  typedef struct {
    bit          d;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] w;
  } txn_t;

  // Reference: one transaction in flight, plus the dbus win streak.
  bit   m_busy;
  bit   m_aok;
  txn_t m_cur;
  int   m_streak;

  logic        o_mv, o_mw, o_ia, o_id, o_da, o_dd;
  logic [31:0] o_ma, o_md, o_idat, o_ddat;
  logic [3:0]  o_ms;
  bit          gq[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_busy   = 0;
    m_aok    = 0;
    m_cur    = '{d: 0, a: 0, s: 0, w: 0};
    m_streak = 0;
  endfunction

  function automatic void mdl_step();
    bit iv, dv, pick_d;
    iv = bus.ireq_valid;
    dv = bus.dreq_valid;
    if (!m_busy) begin
      if (iv || dv) begin
        pick_d = dv && !(iv && m_streak == SMAX);
        if (pick_d && iv)
          m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
        else
          m_streak = 0;
        if (pick_d)
          m_cur = '{d: 1, a: bus.dreq_addr,
                    s: bus.dreq_strobe, w: bus.dreq_data};
        else
          m_cur = '{d: 0, a: bus.ireq_addr, s: 0, w: 0};
        m_busy = 1;
        m_aok  = 0;
      end
    end else if (!m_aok) begin
      if (bus.mresp_addr_ok) begin
        if (bus.mresp_data_ok) m_busy = 0;
        else m_aok = 1;
      end
    end else if (bus.mresp_data_ok) begin
      m_busy = 0;
    end
  endfunction

  // Called at posedge+1; checks at negedge, then advances to posedge+1.
  task automatic cyc();
    bit ea, eb;
    #4;
    if (!resetn) mdl_reset();
    eb = m_busy;
    ea = m_busy && !m_aok;
    o_mv = bus.mreq_valid;     o_mw = bus.mreq_write;
    o_ma = bus.mreq_addr;      o_ms = bus.mreq_strobe;
    o_md = bus.mreq_data;
    o_ia = bus.iresp_addr_ok;  o_id = bus.iresp_data_ok;
    o_da = bus.dresp_addr_ok;  o_dd = bus.dresp_data_ok;
    o_idat = bus.iresp_data;   o_ddat = bus.dresp_data;
    chk("mreq_valid", o_mv, ea);
    chk("mreq_write", o_mw, m_cur.s != 0);
    chk("mreq_addr", o_ma, m_cur.a);
    chk("mreq_strobe", o_ms, m_cur.s);
    chk("mreq_data", o_md, m_cur.w);
    chk("iresp_addr_ok", o_ia,
        ea && !m_cur.d && bus.mresp_addr_ok);
    chk("iresp_data_ok", o_id,
        eb && !m_cur.d && bus.mresp_data_ok);
    chk("dresp_addr_ok", o_da,
        ea && m_cur.d && bus.mresp_addr_ok);
    chk("dresp_data_ok", o_dd,
        eb && m_cur.d && bus.mresp_data_ok);
    chk("iresp_data", o_idat, bus.mresp_data);
    chk("dresp_data", o_ddat, bus.mresp_data);
    if (o_ia) gq.push_back(1'b0);
    if (o_da) gq.push_back(1'b1);
    if (resetn) mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ireq_valid    = 0;
    bus.ireq_addr     = 0;
    bus.dreq_valid    = 0;
    bus.dreq_addr     = 0;
    bus.dreq_strobe   = 0;
    bus.dreq_data     = 0;
    bus.mresp_addr_ok = 0;
    bus.mresp_data_ok = 0;
    bus.mresp_data    = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    cyc();
    cyc();
    resetn = 1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mdl_reset();
    idle_inputs();
    resetn = 0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_mreq_valid", o_mv, 0);
    chk("rst_mreq_write", o_mw, 0);

    // Single fetch with split address/data phases.
    bus.ireq_valid = 1;
    bus.ireq_addr  = 32'hBFC0_0000;
    cyc();
    bus.mresp_addr_ok = 1;
    cyc();
    chk("f_valid", o_mv, 1);
    chk("f_write", o_mw, 0);
    chk("f_addr", o_ma, 32'hBFC0_0000);
    chk("f_aok", o_ia, 1);
    idle_inputs();
    cyc();
    cyc();
    bus.mresp_data_ok = 1;
    bus.mresp_data    = 32'h2408_0001;
    cyc();
    chk("f_dok", o_id, 1);
    chk("f_data", o_idat, 32'h2408_0001);
    chk("f_d_dok", o_dd, 0);
    chk("f_d_aok", o_da, 0);
    idle_inputs();
    cyc();

    // Simultaneous fetch and write: write goes first.
    bus.ireq_valid  = 1;
    bus.ireq_addr   = 32'hBFC0_0004;
    bus.dreq_valid  = 1;
    bus.dreq_addr   = 32'h8000_0010;
    bus.dreq_strobe = 4'hF;
    bus.dreq_data   = 32'hDEAD_BEEF;
    cyc();
    bus.mresp_addr_ok = 1;
    cyc();
    chk("w_aok", o_da, 1);
    chk("w_write", o_mw, 1);
    chk("w_strobe", o_ms, 4'hF);
    chk("w_data", o_md, 32'hDEAD_BEEF);
    bus.dreq_valid    = 0;
    bus.mresp_addr_ok = 0;
    cyc();
    bus.mresp_data_ok = 1;
    cyc();
    chk("w_dok", o_dd, 1);
    bus.mresp_data_ok = 0;
    cyc();
    chk("w_gap", o_mv, 0);
    cyc();
    chk("w_then_i", o_mv, 1);
    chk("w_then_i_wr", o_mw, 0);
    chk("w_then_i_addr", o_ma, 32'hBFC0_0004);
    bus.mresp_addr_ok = 1;
    bus.mresp_data_ok = 1;
    cyc();
    idle_inputs();
    cyc();

    // Combined addr_ok/data_ok in one ADDR cycle.
    bus.dreq_valid = 1;
    bus.dreq_addr  = 32'h8000_0100;
    cyc();
    bus.mresp_addr_ok = 1;
    bus.mresp_data_ok = 1;
    cyc();
    chk("c_aok", o_da, 1);
    chk("c_dok", o_dd, 1);
    idle_inputs();
    cyc();
    chk("c_idle", o_mv, 0);

    // Stray data_ok in IDLE.
    bus.mresp_data_ok = 1;
    cyc();
    chk("s_i_dok", o_id, 0);
    chk("s_d_dok", o_dd, 0);
    bus.mresp_data_ok = 0;
    cyc();
    chk("s_still_idle", o_mv, 0);

    // Reset while in DATA, then a late data_ok.
    bus.dreq_valid = 1;
    bus.dreq_addr  = 32'h8000_0200;
    cyc();
    bus.mresp_addr_ok = 1;
    cyc();
    idle_inputs();
    cyc();
    bus.mresp_data_ok = 1;
    resetn = 0;
    #1;
    chk("ar_dok", bus.dresp_data_ok, 0);
    chk("ar_valid", bus.mreq_valid, 0);
    chk("ar_addr", bus.mreq_addr, 0);
    @(posedge clk);
    #1;
    cyc();
    resetn = 1;
    cyc();
    chk("late_dok", o_dd, 0);
    idle_inputs();
    cyc();

    // Starvation window: dbus held with ibus waiting.
    do_reset();
    gq.delete();
    bus.ireq_valid    = 1;
    bus.ireq_addr     = 32'hBFC0_0040;
    bus.dreq_valid    = 1;
    bus.dreq_addr     = 32'h8000_0300;
    bus.mresp_addr_ok = 1;
    bus.mresp_data_ok = 1;
    for (int n = 0; n < 100 && gq.size() < 10; n++) cyc();
    chk("starve_cnt", gq.size(), 10);
    for (int k = 0; k < 10 && k < gq.size(); k++)
      chk("starve_ord", gq[k], (k % 5) != 4);
    idle_inputs();
    cyc();

    // Randomized traffic, occasional early drops and resets.
    for (int n = 0; n < 3000; n++) begin
      resetn = ($urandom_range(499) != 0);
      if (!(bus.ireq_valid && !o_ia &&
            $urandom_range(15) != 0)) begin
        bus.ireq_valid = ($urandom_range(2) == 0);
        bus.ireq_addr  = $urandom;
      end
      if (!(bus.dreq_valid && !o_da &&
            $urandom_range(15) != 0)) begin
        bus.dreq_valid  = ($urandom_range(2) == 0);
        bus.dreq_addr   = $urandom;
        bus.dreq_strobe =
          $urandom_range(1) ? 4'($urandom) : 4'h0;
        bus.dreq_data   = $urandom;
      end
      bus.mresp_addr_ok = 1'($urandom_range(1));
      bus.mresp_data_ok = ($urandom_range(2) == 0);
      bus.mresp_data    = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
